// File: rtl/pico_bus_pkg.sv
// Shared types and constants for the picorv32 memory bridge.
// Imported by pico_mem_bridge and pico_gpio_regs.
package pico_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_IO,
    REG_NONE
  } region_t;

  localparam logic [1:0] IO_GPIO_OUT  = 2'd0;
  localparam logic [1:0] IO_GPIO_IN   = 2'd1;
  localparam logic [1:0] IO_FETCH_CNT = 2'd2;
  localparam logic [1:0] IO_STATUS    = 2'd3;

  localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/pico_gpio_regs.sv
// GPIO register file: output reg, synchronised input, fetch counter, bus_err.
// Macro BRIDGE_BUSERR_EN enables the sticky bus_err flag.
module pico_gpio_regs
  import pico_bus_pkg::*;
#(
  parameter int GPIO_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [1:0]        i_wr_idx,
  input  logic [31:0]       i_wdata,
  input  logic [3:0]        i_wstrb,
  input  logic              i_fetch_inc,
  input  logic              i_err_set,
  input  logic [1:0]        i_rd_idx,
  input  logic [GPIO_W-1:0] i_gpio_in,
  output logic [31:0]       o_rdata,
  output logic [GPIO_W-1:0] o_gpio_out,
  output logic              o_bus_err
);

  logic [GPIO_W-1:0] r_gpio_out;
  logic [GPIO_W-1:0] r_sync1;
  logic [GPIO_W-1:0] r_sync2;
  logic [31:0]       r_fetch_cnt;
  logic [GPIO_W-1:0] w_gpio_nxt;
  logic              w_gpio_wr;
  logic              w_unused;

  assign w_gpio_wr  = i_wr_en & (i_wr_idx == IO_GPIO_OUT);
  assign o_gpio_out = r_gpio_out;

  // Byte-lane merge of write data into the output register
  always_comb begin
    w_gpio_nxt = r_gpio_out;
    for (int i = 0; i < GPIO_W; i++) begin
      if (i_wstrb[i/8]) w_gpio_nxt[i] = i_wdata[i];
    end
  end

  // Output register, input synchroniser and fetch counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gpio_out  <= '0;
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_fetch_cnt <= '0;
    end else begin
      r_sync1 <= i_gpio_in;
      r_sync2 <= r_sync1;
      if (w_gpio_wr) r_gpio_out <= w_gpio_nxt;
      if (i_fetch_inc) r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

`ifdef BRIDGE_BUSERR_EN
  logic r_bus_err;
  logic w_err_clr;

  assign w_err_clr = i_wr_en & (i_wr_idx == IO_STATUS)
                   & i_wstrb[0] & i_wdata[0];
  assign o_bus_err = r_bus_err;
  assign w_unused  = ^{i_wdata, i_wstrb};

  // Sticky unmapped-access flag, cleared by writing 1 to status bit0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bus_err <= 1'b0;
    end else if (i_err_set) begin
      r_bus_err <= 1'b1;
    end else if (w_err_clr) begin
      r_bus_err <= 1'b0;
    end
  end
`else
  assign o_bus_err = 1'b0;
  assign w_unused  = ^{i_wdata, i_wstrb, i_err_set};
`endif

  // IO read mux, zero-extending the narrow GPIO words
  always_comb begin
    o_rdata = '0;
    unique case (i_rd_idx)
      IO_GPIO_OUT:  o_rdata = 32'(r_gpio_out);
      IO_GPIO_IN:   o_rdata = 32'(r_sync2);
      IO_FETCH_CNT: o_rdata = r_fetch_cnt;
      IO_STATUS:    o_rdata = {31'b0, o_bus_err};
      default:      o_rdata = '0;
    endcase
  end

endmodule

// File: rtl/pico_mem_bridge.sv
// picorv32 native bus to sync RAM + GPIO bridge with wait states.
// Macro BRIDGE_BUSERR_EN enables bus_err and DEADBEEF unmapped reads.
module pico_mem_bridge
  import pico_bus_pkg::*;
#(
  parameter int          ADDR_W      = 15,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] IO_BASE     = 32'h1000_0000,
  parameter int          GPIO_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_instr,
  output logic              mem_ready,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_byteena,
  output logic [31:0]       ram_wdata,
  output logic              ram_wren,
  input  logic [31:0]       ram_q,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              bus_err
);

`ifdef BRIDGE_BUSERR_EN
  localparam logic [31:0] UNMAPPED = DEADBEEF;
`else
  localparam logic [31:0] UNMAPPED = 32'h0;
`endif

  state_t      r_state;
  region_t     r_region;
  logic [3:0]  r_wcnt;
  logic [1:0]  r_idx;
  logic        r_instr;
  logic        r_first;
  logic [31:0] r_hold;

  region_t     w_region;
  logic [31:0] w_hi;
  logic        w_accept;
  logic        w_wr;
  logic        w_done;
  logic [31:0] w_io_rdata;
  logic [31:0] w_rd_mux;
  logic        w_unused;

  assign ram_addr    = mem_addr[ADDR_W+1:2];
  assign ram_byteena = mem_wstrb;
  assign ram_wdata   = mem_wdata;
  assign w_unused    = ^mem_addr[1:0];

  assign w_hi     = mem_addr >> (ADDR_W + 2);
  assign w_accept = (r_state == IDLE) & mem_valid;
  assign w_wr     = |mem_wstrb;
  assign ram_wren = w_accept & (w_region == REG_RAM) & w_wr;
  assign w_done   = (r_state == WAIT) & mem_valid & (r_wcnt == 4'd0);

  // Address decode into RAM / IO / unmapped
  always_comb begin
    w_region = REG_NONE;
    unique case (1'b1)
      (w_hi == 32'd0):                  w_region = REG_RAM;
      (mem_addr[31:4] == IO_BASE[31:4]): w_region = REG_IO;
      default:                          w_region = REG_NONE;
    endcase
  end

  pico_gpio_regs #(
    .GPIO_W (GPIO_W)
  ) u_gpio (
    .clk         (clk),
    .rst         (rst),
    .i_wr_en     (w_accept & (w_region == REG_IO) & w_wr),
    .i_wr_idx    (mem_addr[3:2]),
    .i_wdata     (mem_wdata),
    .i_wstrb     (mem_wstrb),
    .i_fetch_inc (w_done & r_instr),
    .i_err_set   (w_accept & (w_region == REG_NONE)),
    .i_rd_idx    (r_idx),
    .i_gpio_in   (gpio_in),
    .o_rdata     (w_io_rdata),
    .o_gpio_out  (gpio_out),
    .o_bus_err   (bus_err)
  );

  // Response data mux; RAM data is the word as read on the accept edge
  always_comb begin
    w_rd_mux = UNMAPPED;
    unique case (1'b1)
      (r_region == REG_RAM): w_rd_mux = r_first ? ram_q : r_hold;
      (r_region == REG_IO):  w_rd_mux = w_io_rdata;
      default:               w_rd_mux = UNMAPPED;
    endcase
  end

  // Request FSM with wait-state counter and registered response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_region  <= REG_NONE;
      r_wcnt    <= '0;
      r_idx     <= '0;
      r_instr   <= 1'b0;
      r_first   <= 1'b0;
      r_hold    <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (mem_valid) begin
            r_wcnt   <= 4'(WAIT_STATES);
            r_region <= w_region;
            r_idx    <= mem_addr[3:2];
            r_instr  <= mem_instr;
            r_first  <= 1'b1;
            r_state  <= WAIT;
          end
        end
        WAIT: begin
          r_first <= 1'b0;
          if (r_first) r_hold <= ram_q;
          if (!mem_valid) begin
            r_state <= IDLE;
          end else if (r_wcnt != 4'd0) begin
            r_wcnt <= r_wcnt - 4'd1;
          end else begin
            mem_rdata <= w_rd_mux;
            mem_ready <= 1'b1;
            r_state   <= RESP;
          end
        end
        RESP: begin
          mem_ready <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
